// File: rtl/switch_allocator_pkg.sv
// Shared constants and types for the router switch allocator: port indices,
// flit type codes, crossbar select encoding and small decode helpers.
package switch_allocator_pkg;

  localparam int unsigned NPORT = 5;
  localparam int unsigned SEL_W = 3;
  localparam logic [SEL_W-1:0] SEL_NONE = 3'd7;

  // Port order matches the one-hot bit order produced by route compute.
  localparam int unsigned PORT_L = 0;
  localparam int unsigned PORT_E = 1;
  localparam int unsigned PORT_W = 2;
  localparam int unsigned PORT_S = 3;
  localparam int unsigned PORT_N = 4;

  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_TAIL   = 2'b01,
    FLIT_HDR    = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_t;

  typedef enum logic {
    OUT_IDLE,
    OUT_BUSY
  } out_state_t;

  // HDR and SINGLE both open a packet; TAIL and SINGLE both close one.
  function automatic logic is_head(input logic [1:0] t);
    return t[1];
  endfunction

  function automatic logic is_last(input logic [1:0] t);
    return t[0];
  endfunction

  function automatic logic is_onehot(input logic [NPORT-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] w);
    return (w >= SEL_W'(NPORT - 1)) ? '0 : w + 1'b1;
  endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Flit handshake and crossbar select bundle between the input stages,
// the switch allocator and the crossbar.
interface switch_allocator_if;
  import switch_allocator_pkg::*;

  logic [NPORT-1:0]       in_valid;
  logic [2*NPORT-1:0]     in_type;
  logic [NPORT*NPORT-1:0] in_route;
  logic [NPORT-1:0]       out_ready;
  logic [NPORT-1:0]       in_ready;
  logic [NPORT-1:0]       out_valid;
  logic [NPORT*SEL_W-1:0] out_sel;

  modport master (
    output in_valid, in_type, in_route, out_ready,
    input  in_ready, out_valid, out_sel
  );

  modport slave (
    input  in_valid, in_type, in_route, out_ready,
    output in_ready, out_valid, out_sel
  );

endinterface

// File: rtl/switch_allocator_rr_arbiter5.sv
// Combinational five-way round-robin arbiter: the search starts at ptr and
// wraps, returning a one-hot grant and its encoded index (SEL_NONE if idle).
module rr_arbiter5
  import switch_allocator_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [NPORT-1:0] grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic [SEL_W-1:0] start;
  logic [SEL_W:0]   sum;
  logic [SEL_W-1:0] idx;
  logic             found;

  assign start = (ptr >= SEL_W'(NPORT)) ? '0 : ptr;

  always_comb begin
    grant     = '0;
    grant_idx = SEL_NONE;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NPORT; k++) begin
      sum = {1'b0, start} + (SEL_W + 1)'(k);
      if (sum >= (SEL_W + 1)'(NPORT)) begin
        sum = sum - (SEL_W + 1)'(NPORT);
      end
      idx = sum[SEL_W-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: one round-robin arbiter and lock FSM per output,
// driving crossbar selects and per-input/per-output flit handshakes.
module switch_allocator
  import switch_allocator_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  switch_allocator_if.slave  sw
);

  out_state_t       state     [NPORT];
  logic [SEL_W-1:0] owner     [NPORT];
  logic [SEL_W-1:0] ptr       [NPORT];
  logic [NPORT-1:0] req_out   [NPORT];
  logic [NPORT-1:0] grant     [NPORT];
  logic [SEL_W-1:0] grant_idx [NPORT];

  logic [NPORT-1:0]       owned;
  logic [NPORT-1:0]       head_req;
  logic [NPORT-1:0]       owner_valid;
  logic [NPORT-1:0]       owner_last;
  logic [NPORT-1:0]       xfer;
  logic [NPORT-1:0]       in_ready_c;
  logic [NPORT*SEL_W-1:0] out_sel_c;

  // Owned inputs are masked out so an input can never hold two outputs.
  always_comb begin
    owned    = '0;
    head_req = '0;
    for (int unsigned o = 0; o < NPORT; o++) begin
      for (int unsigned i = 0; i < NPORT; i++) begin
        if (owner[o] == SEL_W'(i)) begin
          owned[i] = 1'b1;
        end
      end
    end
    for (int unsigned i = 0; i < NPORT; i++) begin
      head_req[i] = sw.in_valid[i] & is_head(sw.in_type[2*i +: 2])
                  & is_onehot(sw.in_route[NPORT*i +: NPORT]) & ~owned[i];
    end
  end

  always_comb begin
    for (int unsigned o = 0; o < NPORT; o++) begin
      req_out[o] = '0;
      for (int unsigned i = 0; i < NPORT; i++) begin
        req_out[o][i] = head_req[i] & sw.in_route[NPORT*i + o];
      end
    end
  end

  for (genvar o = 0; o < NPORT; o++) begin : g_arb
    rr_arbiter5 u_arb (
      .req       (req_out[o]),
      .ptr       (ptr[o]),
      .grant     (grant[o]),
      .grant_idx (grant_idx[o])
    );
  end

  // Owner is SEL_NONE while idle, so matching it alone gates the handshakes.
  always_comb begin
    owner_valid = '0;
    owner_last  = '0;
    in_ready_c  = '0;
    out_sel_c   = '0;
    for (int unsigned o = 0; o < NPORT; o++) begin
      out_sel_c[SEL_W*o +: SEL_W] = owner[o];
      for (int unsigned i = 0; i < NPORT; i++) begin
        if (owner[o] == SEL_W'(i)) begin
          owner_valid[o] = sw.in_valid[i];
          owner_last[o]  = is_last(sw.in_type[2*i +: 2]);
          if (sw.out_ready[o]) begin
            in_ready_c[i] = 1'b1;
          end
        end
      end
    end
    xfer = owner_valid & sw.out_ready;
  end

  assign sw.in_ready  = in_ready_c;
  assign sw.out_valid = owner_valid;
  assign sw.out_sel   = out_sel_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned o = 0; o < NPORT; o++) begin
        state[o] <= OUT_IDLE;
        owner[o] <= SEL_NONE;
        ptr[o]   <= '0;
      end
    end else begin
      for (int unsigned o = 0; o < NPORT; o++) begin
        case (state[o])
          OUT_IDLE: begin
            if (|grant[o]) begin
              owner[o] <= grant_idx[o];
              state[o] <= OUT_BUSY;
            end
          end
          OUT_BUSY: begin
            if (xfer[o] && owner_last[o]) begin
              owner[o] <= SEL_NONE;
              ptr[o]   <= next_ptr(owner[o]);
              state[o] <= OUT_IDLE;
            end
          end
          default: begin
            owner[o] <= SEL_NONE;
            state[o] <= OUT_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: a cycle-by-cycle vector table plus a
// hand-written asynchronous reset sequence, with hand-computed expectations.
module tb_switch_allocator;
  import switch_allocator_pkg::*;

  localparam logic [1:0]  HD = 2'b10;
  localparam logic [1:0]  BD = 2'b00;
  localparam logic [1:0]  TL = 2'b01;
  localparam logic [1:0]  SG = 2'b11;
  localparam logic [4:0]  RL = 5'b00001;
  localparam logic [4:0]  RE = 5'b00010;
  localparam logic [4:0]  RW = 5'b00100;
  localparam logic [4:0]  RS = 5'b01000;
  localparam logic [4:0]  RN = 5'b10000;
  localparam logic [4:0]  RZ = 5'b00000;
  localparam logic [4:0]  RBAD = 5'b00110;
  localparam logic [4:0]  ALL = 5'b11111;
  localparam logic [4:0]  Z5 = 5'b00000;
  localparam logic [2:0]  NS = 3'd7;
  localparam logic [14:0] NONE_ALL = 15'h7FFF;

  typedef struct {
    string      name;
    logic [4:0]  valid;
    logic [9:0]  typ;
    logic [24:0] route;
    logic [4:0]  ready;
    logic [4:0]  exp_in_ready;
    logic [4:0]  exp_out_valid;
    logic [14:0] exp_sel;
  } vec_t;

  vec_t vecs[$];

  logic clk = 1'b0;
  logic rst;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  switch_allocator_if sw_if ();

  switch_allocator dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw_if)
  );

  function automatic logic [9:0] ty(input logic [1:0] t0, t1, t2, t3, t4);
    return {t4, t3, t2, t1, t0};
  endfunction

  function automatic logic [24:0] rt(input logic [4:0] r0, r1, r2, r3, r4);
    return {r4, r3, r2, r1, r0};
  endfunction

  function automatic logic [14:0] sel(input logic [2:0] l, e, w, s, n);
    return {n, s, w, e, l};
  endfunction

  function automatic void add(input string n, input logic [4:0] v, input logic [9:0] t,
                              input logic [24:0] r, input logic [4:0] rdy,
                              input logic [4:0] ir, input logic [4:0] ov, input logic [14:0] s);
    vec_t x;
    x.name = n; x.valid = v; x.typ = t; x.route = r; x.ready = rdy;
    x.exp_in_ready = ir; x.exp_out_valid = ov; x.exp_sel = s;
    vecs.push_back(x);
  endfunction

  task automatic drive(input logic [4:0] v, input logic [9:0] t, input logic [24:0] r,
                       input logic [4:0] rdy);
    sw_if.in_valid  = v;
    sw_if.in_type   = t;
    sw_if.in_route  = r;
    sw_if.out_ready = rdy;
  endtask

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [4:0] ir, input logic [4:0] ov,
                            input logic [14:0] s);
    check({name, "/in_ready"}, {10'b0, sw_if.in_ready}, {10'b0, ir});
    check({name, "/out_valid"}, {10'b0, sw_if.out_valid}, {10'b0, ov});
    check({name, "/out_sel"}, sw_if.out_sel, s);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Single packet HDR/BODY/TAIL from input 1 to E.
    add("pkt_alloc",   5'b00010, ty(BD,HD,BD,BD,BD), rt(RZ,RE,RZ,RZ,RZ), ALL, Z5, Z5, NONE_ALL);
    add("pkt_hdr",     5'b00010, ty(BD,HD,BD,BD,BD), rt(RZ,RE,RZ,RZ,RZ), ALL, 5'b00010, 5'b00010, sel(NS,3'd1,NS,NS,NS));
    add("pkt_body",    5'b00010, ty(BD,BD,BD,BD,BD), rt(RZ,RE,RZ,RZ,RZ), ALL, 5'b00010, 5'b00010, sel(NS,3'd1,NS,NS,NS));
    add("pkt_tail",    5'b00010, ty(BD,TL,BD,BD,BD), rt(RZ,RE,RZ,RZ,RZ), ALL, 5'b00010, 5'b00010, sel(NS,3'd1,NS,NS,NS));
    add("pkt_release", Z5, ty(BD,BD,BD,BD,BD), rt(RZ,RZ,RZ,RZ,RZ), ALL, Z5, Z5, NONE_ALL);
    // Contention: 0, 2, 4 single-flit to S, then pointer-wrap probe with 0 and 4.
    add("cont_alloc0", 5'b10101, ty(SG,BD,SG,BD,SG), rt(RS,RZ,RS,RZ,RS), ALL, Z5, Z5, NONE_ALL);
    add("cont_xfer0",  5'b10101, ty(SG,BD,SG,BD,SG), rt(RS,RZ,RS,RZ,RS), ALL, 5'b00001, 5'b01000, sel(NS,NS,NS,3'd0,NS));
    add("cont_alloc2", 5'b10100, ty(SG,BD,SG,BD,SG), rt(RS,RZ,RS,RZ,RS), ALL, Z5, Z5, NONE_ALL);
    add("cont_xfer2",  5'b10100, ty(SG,BD,SG,BD,SG), rt(RS,RZ,RS,RZ,RS), ALL, 5'b00100, 5'b01000, sel(NS,NS,NS,3'd2,NS));
    add("cont_alloc4", 5'b10000, ty(SG,BD,SG,BD,SG), rt(RS,RZ,RS,RZ,RS), ALL, Z5, Z5, NONE_ALL);
    add("cont_xfer4",  5'b10000, ty(SG,BD,SG,BD,SG), rt(RS,RZ,RS,RZ,RS), ALL, 5'b10000, 5'b01000, sel(NS,NS,NS,3'd4,NS));
    add("wrap_alloc",  5'b10001, ty(SG,BD,SG,BD,SG), rt(RS,RZ,RS,RZ,RS), ALL, Z5, Z5, NONE_ALL);
    add("wrap_xfer0",  5'b10001, ty(SG,BD,SG,BD,SG), rt(RS,RZ,RS,RZ,RS), ALL, 5'b00001, 5'b01000, sel(NS,NS,NS,3'd0,NS));
    add("wrap_alloc4", 5'b10000, ty(SG,BD,SG,BD,SG), rt(RS,RZ,RS,RZ,RS), ALL, Z5, Z5, NONE_ALL);
    add("wrap_xfer4",  5'b10000, ty(SG,BD,SG,BD,SG), rt(RS,RZ,RS,RZ,RS), ALL, 5'b10000, 5'b01000, sel(NS,NS,NS,3'd4,NS));
    add("cont_idle",   Z5, ty(BD,BD,BD,BD,BD), rt(RZ,RZ,RZ,RZ,RZ), ALL, Z5, Z5, NONE_ALL);
    // Back-pressure on N while input 1 waits with a competing header.
    add("bp_alloc",    5'b01000, ty(BD,BD,BD,HD,BD), rt(RZ,RZ,RZ,RN,RZ), ALL, Z5, Z5, NONE_ALL);
    add("bp_hdr",      5'b01010, ty(BD,HD,BD,HD,BD), rt(RZ,RN,RZ,RN,RZ), ALL, 5'b01000, 5'b10000, sel(NS,NS,NS,NS,3'd3));
    add("bp_stall1",   5'b01010, ty(BD,HD,BD,BD,BD), rt(RZ,RN,RZ,RN,RZ), 5'b01111, Z5, 5'b10000, sel(NS,NS,NS,NS,3'd3));
    add("bp_stall2",   5'b01010, ty(BD,HD,BD,BD,BD), rt(RZ,RN,RZ,RN,RZ), 5'b01111, Z5, 5'b10000, sel(NS,NS,NS,NS,3'd3));
    add("bp_stall3",   5'b01010, ty(BD,HD,BD,BD,BD), rt(RZ,RN,RZ,RN,RZ), 5'b01111, Z5, 5'b10000, sel(NS,NS,NS,NS,3'd3));
    add("bp_body",     5'b01010, ty(BD,HD,BD,BD,BD), rt(RZ,RN,RZ,RN,RZ), ALL, 5'b01000, 5'b10000, sel(NS,NS,NS,NS,3'd3));
    add("bp_tail",     5'b01010, ty(BD,HD,BD,TL,BD), rt(RZ,RN,RZ,RN,RZ), ALL, 5'b01000, 5'b10000, sel(NS,NS,NS,NS,3'd3));
    add("bp_alloc1",   5'b00010, ty(BD,HD,BD,BD,BD), rt(RZ,RN,RZ,RZ,RZ), ALL, Z5, Z5, NONE_ALL);
    add("bp_hdr1",     5'b00010, ty(BD,HD,BD,BD,BD), rt(RZ,RN,RZ,RZ,RZ), ALL, 5'b00010, 5'b10000, sel(NS,NS,NS,NS,3'd1));
    add("bp_tail1",    5'b00010, ty(BD,TL,BD,BD,BD), rt(RZ,RN,RZ,RZ,RZ), ALL, 5'b00010, 5'b10000, sel(NS,NS,NS,NS,3'd1));
    add("bp_idle",     Z5, ty(BD,BD,BD,BD,BD), rt(RZ,RZ,RZ,RZ,RZ), ALL, Z5, Z5, NONE_ALL);
    // Independent outputs L and W granted in parallel.
    add("par_alloc",   5'b01001, ty(SG,BD,BD,SG,BD), rt(RL,RZ,RZ,RW,RZ), ALL, Z5, Z5, NONE_ALL);
    add("par_xfer",    5'b01001, ty(SG,BD,BD,SG,BD), rt(RL,RZ,RZ,RW,RZ), ALL, 5'b01001, 5'b00101, sel(3'd0,NS,3'd3,NS,NS));
    add("par_idle",    Z5, ty(BD,BD,BD,BD,BD), rt(RZ,RZ,RZ,RZ,RZ), ALL, Z5, Z5, NONE_ALL);
    // Bad routes on inputs 1 and 2 never granted; input 4 proceeds.
    add("bad_alloc",   5'b10110, ty(BD,HD,HD,BD,SG), rt(RZ,RBAD,RZ,RZ,RS), ALL, Z5, Z5, NONE_ALL);
    add("bad_other",   5'b10110, ty(BD,HD,HD,BD,SG), rt(RZ,RBAD,RZ,RZ,RS), ALL, 5'b10000, 5'b01000, sel(NS,NS,NS,3'd4,NS));
    add("bad_stall1",  5'b00110, ty(BD,HD,HD,BD,SG), rt(RZ,RBAD,RZ,RZ,RS), ALL, Z5, Z5, NONE_ALL);
    add("bad_stall2",  5'b00110, ty(BD,HD,HD,BD,SG), rt(RZ,RBAD,RZ,RZ,RS), ALL, Z5, Z5, NONE_ALL);
    add("bad_idle",    Z5, ty(BD,BD,BD,BD,BD), rt(RZ,RZ,RZ,RZ,RZ), ALL, Z5, Z5, NONE_ALL);

    rst = 1'b1;
    drive(Z5, '0, '0, ALL);
    #12;
    check_outs("reset", Z5, Z5, NONE_ALL);
    #1 rst = 1'b0;
    next_cycle();

    foreach (vecs[k]) begin
      drive(vecs[k].valid, vecs[k].typ, vecs[k].route, vecs[k].ready);
      #1;
      check_outs(vecs[k].name, vecs[k].exp_in_ready, vecs[k].exp_out_valid, vecs[k].exp_sel);
      next_cycle();
    end

    // Input 2 owns E mid-packet; async reset must drop the lock at once.
    drive(5'b00100, ty(BD,BD,HD,BD,BD), rt(RZ,RZ,RE,RZ,RZ), ALL);
    #1 check_outs("rst_alloc", Z5, Z5, NONE_ALL);
    next_cycle();
    drive(5'b00100, ty(BD,BD,HD,BD,BD), rt(RZ,RZ,RE,RZ,RZ), ALL);
    #1 check_outs("rst_hdr", 5'b00100, 5'b00010, sel(NS,3'd2,NS,NS,NS));
    next_cycle();
    drive(5'b00100, ty(BD,BD,BD,BD,BD), rt(RZ,RZ,RE,RZ,RZ), ALL);
    #1 check_outs("rst_body", 5'b00100, 5'b00010, sel(NS,3'd2,NS,NS,NS));
    next_cycle();
    drive(5'b00100, ty(BD,BD,TL,BD,BD), rt(RZ,RZ,RE,RZ,RZ), ALL);
    #1 check_outs("rst_pre", 5'b00100, 5'b00010, sel(NS,3'd2,NS,NS,NS));
    #1 rst = 1'b1;
    #1 check_outs("rst_async", Z5, Z5, NONE_ALL);
    @(posedge clk);
    #3 rst = 1'b0;
    next_cycle();

    // Pointer back at 0: input 1 beats input 2 for E after reset.
    drive(5'b00110, ty(BD,SG,HD,BD,BD), rt(RZ,RE,RE,RZ,RZ), ALL);
    #1 check_outs("post_alloc", Z5, Z5, NONE_ALL);
    next_cycle();
    drive(5'b00110, ty(BD,SG,HD,BD,BD), rt(RZ,RE,RE,RZ,RZ), ALL);
    #1 check_outs("post_xfer1", 5'b00010, 5'b00010, sel(NS,3'd1,NS,NS,NS));
    next_cycle();
    drive(5'b00100, ty(BD,BD,HD,BD,BD), rt(RZ,RZ,RE,RZ,RZ), ALL);
    #1 check_outs("post_alloc2", Z5, Z5, NONE_ALL);
    next_cycle();
    drive(5'b00100, ty(BD,BD,HD,BD,BD), rt(RZ,RZ,RE,RZ,RZ), ALL);
    #1 check_outs("post_hdr2", 5'b00100, 5'b00010, sel(NS,3'd2,NS,NS,NS));
    next_cycle();
    drive(5'b00100, ty(BD,BD,TL,BD,BD), rt(RZ,RZ,RE,RZ,RZ), ALL);
    #1 check_outs("post_tail2", 5'b00100, 5'b00010, sel(NS,3'd2,NS,NS,NS));
    next_cycle();
    drive(Z5, '0, '0, ALL);
    #1 check_outs("post_idle", Z5, Z5, NONE_ALL);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Allocates the five router output ports (L, E, W, S, N) among the five input ports, using the one-hot route requests produced by route computation.
- Each output port runs a round-robin arbiter over header flits and locks to the winning input until that packet's tail flit has been transferred (wormhole switching).
- Drives the crossbar select lines and the per-input/per-output flit handshakes.
- Sits between the per-input route compute stage and the crossbar inside each router.

Parameters:
- NPORT, 5, number of input ports and number of output ports
- SEL_W, 3, width of one encoded crossbar select / owner index
- SEL_NONE, 7, select value meaning "no input connected"

Ports:
- clk  input  1  router clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  5  input i has a flit at its head
- in_type  input  10  2 bits per input: 2'b10 HDR, 2'b00 BODY, 2'b01 TAIL, 2'b11 single-flit (HDR+TAIL)
- in_route  input  25  5 bits per input, one-hot requested output: bit0 L, bit1 E, bit2 W, bit3 S, bit4 N
- out_ready  input  5  downstream of output o can accept a flit this cycle
- in_ready  output  5  flit at input i is consumed this cycle
- out_valid  output  5  output o presents a flit this cycle
- out_sel  output  15  3 bits per output: index of the connected input, or SEL_NONE

Behaviour:
- Interface is fixed: one clock, clk; rst is asynchronous and active-high.
- Reset (async assert; release is sampled on clk) puts the following in reset state:
  - all outputs in IDLE; out_valid=0, in_ready=0, every out_sel=SEL_NONE
  - all round-robin pointers=0, so input 0 has highest priority
  - all owner registers=SEL_NONE
- Reset mid-packet drops all locks. Partially sent packets are not resumed; upstream is responsible for flushing.
- Request rule: input i requests output o when in_valid[i] & in_type[i] in {HDR, single} & in_route[i][o] & input i is not already owned by any output.
- A route that is not one-hot (zero, or more than one bit set) generates no request. That input stalls and is never granted.
- Per-output FSM, IDLE:
  - round-robin arbitration over requesting inputs, searching from pointer p upward with wrap (p, p+1, ... 4, 0, ... p-1)
  - a winner w is registered as owner; the FSM goes to BUSY at the next edge
  - no flit moves in the IDLE cycle, so allocation latency is 1 cycle and the header transfers at the earliest in the following cycle
  - with no requesters the FSM stays in IDLE and the pointer is unchanged
- Per-output FSM, BUSY (owner w):
  - out_sel[o]=w
  - out_valid[o]=in_valid[w]
  - in_ready[w]=out_ready[o]
  - a transfer happens when in_valid[w] & out_ready[o] in the same cycle
  - on transfer of a TAIL or single-flit: next state IDLE, owner=SEL_NONE, pointer=(w+1) mod 5, out_sel returns to SEL_NONE next cycle
  - otherwise the FSM stays in BUSY; bubbles (in_valid[w]=0) and back-pressure (out_ready=0) hold the lock indefinitely
- Simultaneous events:
  - a tail transfer in cycle t and a new header for the same output: the new header can win arbitration at t+1 (the output is IDLE at t+1) and transfers at t+2
  - different outputs arbitrate independently in the same cycle; one input can never own two outputs, because its route is one-hot and it is excluded while it holds ownership
- in_ready[i]=0 whenever input i is unowned.
- The header must stay stable until it is transferred; the allocator does not latch flit contents.
- Timing: all outputs are combinational from the registered state plus in_valid/out_ready. No combinational path from in_route to in_ready within the same cycle.

Decomposition:
- Shared package/header holds:
  - flit type codes (HDR, BODY, TAIL, SINGLE)
  - port index constants (L=0, E=1, W=2, S=3, N=4), matching the route-compute one-hot bit order
  - SEL_NONE
- One natural sub-module: rr_arbiter5. It takes a 5-bit request vector and a 3-bit pointer and returns a one-hot grant plus the encoded index, combinationally. It is instantiated once per output; the FSM, owner and pointer registers stay in switch_allocator.

Test Plan:
- Single packet:
  - stimulus: input 1 sends HDR, BODY, TAIL with route=E (5'b00010), out_ready=1
  - required response: out_sel[E]=1 one cycle after the header appears; three transfers on consecutive cycles; out_sel[E]=7 after the tail
- Contention:
  - stimulus: inputs 0, 2 and 4 all present single-flit packets to S at once, pointer=0, out_ready=1; requests held
  - required response: grants go to 0, then 2, then 4; each transfer is followed by an allocation cycle; the pointer finishes at 0
- Back-pressure:
  - stimulus: mid-packet, out_ready[N]=0 for 3 cycles
  - required response: in_ready of the owner is 0 for those cycles; the lock is held; a competing header to N is not granted until after the tail
- Independent outputs:
  - stimulus: input 0 targets L while input 3 targets W in the same cycle
  - required response: both are granted in parallel; out_sel[L]=0 and out_sel[W]=3
- Reset mid-packet:
  - stimulus: assert rst asynchronously between clock edges while input 2 owns E after its BODY flit
  - required response: out_valid, in_ready and pointers go to 0 and out_sel to 7 immediately; after release, a new header from input 2 re-arbitrates normally
- Bad route:
  - stimulus: header with route=5'b00110 (two bits set) or 5'b00000
  - required response: never granted; in_ready stays 0; other inputs are unaffected
